// File: rtl/ps2_movement_decoder.sv
// ============================================================================
// ps2_movement_decoder
// ----------------------------------------------------------------------------
// Purpose:
//   Converts the stream of received PS/2 bytes into per-frame movement pulses
//   for the player position/angle update stage. The parser understands make
//   codes, the break prefix (F0) and the extended prefix (E0), and it tracks
//   which movement keys are currently held. An internal tick divider sets the
//   movement rate, so player speed does not depend on the keyboard's
//   typematic repeat rate.
//
//   Each key class (forward, backward, rotate) has two held bits, one for the
//   plain key (W/S/D) and one for the extended arrow key (Up/Down/Right).
//   Keeping them separate means that releasing one key while its partner is
//   still down leaves the class held. Each class also has a pending bit. A make
//   code sets it and a tick clears it. A quick tap that is pressed and released
//   between two ticks therefore still produces one movement step.
//
// Parameters:
//   TICK_DIV  - clock cycles per movement tick (minimum 2)
//   KEY_FWD   - plain forward make code  (extended Up    0x75 is also forward)
//   KEY_BACK  - plain backward make code (extended Down  0x72 is also backward)
//   KEY_ROT   - plain rotate make code   (extended Right 0x74 is also rotate)
//
// Ports:
//   clock          in   system clock
//   reset          in   synchronous, active-high reset
//   scancode       in   [7:0] received PS/2 byte
//   scancode_valid in   one-cycle strobe qualifying scancode
//   forward        out  one-cycle pulse: move forward this tick
//   backward       out  one-cycle pulse: move backward this tick
//   rotate         out  one-cycle pulse: rotate one step this tick
//   keys_held      out  [2:0] {rot, back, fwd} held status (plain OR extended)
//   tick           out  one-cycle movement-tick strobe
// ============================================================================
module ps2_movement_decoder #(
    parameter int unsigned TICK_DIV = 833333,
    parameter logic [7:0]  KEY_FWD  = 8'h1D,
    parameter logic [7:0]  KEY_BACK = 8'h1B,
    parameter logic [7:0]  KEY_ROT  = 8'h23
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] scancode,
    input  logic       scancode_valid,
    output logic       forward,
    output logic       backward,
    output logic       rotate,
    output logic [2:0] keys_held,
    output logic       tick
);

    // Prefix bytes and the fixed extended arrow-key codes.
    localparam logic [7:0] CODE_EXT   = 8'hE0;
    localparam logic [7:0] CODE_BRK   = 8'hF0;
    localparam logic [7:0] EXT_UP     = 8'h75;
    localparam logic [7:0] EXT_DOWN   = 8'h72;
    localparam logic [7:0] EXT_RIGHT  = 8'h74;

    // Tick counter sizing. The counter runs 0..TICK_DIV-1.
    localparam int unsigned     CNT_W   = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

    // Bit positions inside every 3-bit key vector: {rot, back, fwd}.
    localparam int BIT_FWD  = 0;
    localparam int BIT_BACK = 1;
    localparam int BIT_ROT  = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } state_t;

    // ------------------------------------------------------------------------
    // Key mapping helpers: one-hot {rot, back, fwd} for a code, 0 if unmapped.
    // ------------------------------------------------------------------------
    function automatic logic [2:0] map_plain(input logic [7:0] code);
        logic [2:0] m;
        m = 3'b000;
        if (code == KEY_FWD)  m[BIT_FWD]  = 1'b1;
        if (code == KEY_BACK) m[BIT_BACK] = 1'b1;
        if (code == KEY_ROT)  m[BIT_ROT]  = 1'b1;
        return m;
    endfunction

    function automatic logic [2:0] map_ext(input logic [7:0] code);
        logic [2:0] m;
        m = 3'b000;
        if (code == EXT_UP)    m[BIT_FWD]  = 1'b1;
        if (code == EXT_DOWN)  m[BIT_BACK] = 1'b1;
        if (code == EXT_RIGHT) m[BIT_ROT]  = 1'b1;
        return m;
    endfunction

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    state_t           state_q,      state_d;
    logic [CNT_W-1:0] count_q,      count_d;
    logic [2:0]       held_plain_q, held_plain_d;
    logic [2:0]       held_ext_q,   held_ext_d;
    logic [2:0]       pend_q,       pend_d;
    logic             forward_q,    forward_d;
    logic             backward_q,   backward_d;
    logic             rotate_q,     rotate_d;

    // Parser actions produced by the FSM output process.
    logic [2:0] set_plain;
    logic [2:0] set_ext;
    logic [2:0] clr_plain;
    logic [2:0] clr_ext;

    // Effective per-class request seen at the tick.
    logic [2:0] eff;

    // ------------------------------------------------------------------------
    // FSM process 1: state register. A reset mid-sequence discards any
    // pending prefix, so the next byte is parsed from IDLE.
    // ------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------------
    // FSM process 2: next-state logic. Advances only on scancode_valid.
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (scancode_valid) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (scancode == CODE_EXT) begin
                        state_d = ST_EXT;
                    end else if (scancode == CODE_BRK) begin
                        state_d = ST_BRK;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_EXT: begin
                    // A repeated E0 keeps the extended context alive.
                    if (scancode == CODE_BRK) begin
                        state_d = ST_EXT_BRK;
                    end else if (scancode == CODE_EXT) begin
                        state_d = ST_EXT;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_BRK:     state_d = ST_IDLE;
                ST_EXT_BRK: state_d = ST_IDLE;
                default:    state_d = ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // FSM process 3: output decode. Turns the current byte into set/clear
    // masks for the plain and extended held bits. Unmapped codes map to zero
    // masks, so they are no-ops.
    // ------------------------------------------------------------------------
    always_comb begin
        set_plain = 3'b000;
        set_ext   = 3'b000;
        clr_plain = 3'b000;
        clr_ext   = 3'b000;
        if (scancode_valid) begin
            unique case (state_q)
                ST_IDLE: begin
                    if ((scancode != CODE_EXT) && (scancode != CODE_BRK)) begin
                        set_plain = map_plain(scancode);
                    end
                end
                ST_EXT: begin
                    if ((scancode != CODE_EXT) && (scancode != CODE_BRK)) begin
                        set_ext = map_ext(scancode);
                    end
                end
                ST_BRK:     clr_plain = map_plain(scancode);
                ST_EXT_BRK: clr_ext   = map_ext(scancode);
                default: begin
                    set_plain = 3'b000;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Movement tick divider: free-running 0..TICK_DIV-1, with the strobe in
    // the terminal-count cycle.
    // ------------------------------------------------------------------------
    assign tick = (count_q == CNT_MAX);

    always_comb begin
        if (tick) begin
            count_d = '0;
        end else begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // ------------------------------------------------------------------------
    // Held and pending bits. Typematic repeats re-set bits that are already
    // set, so they are harmless. The tick clears the pending bits before new
    // makes are OR-ed in. A make that lands in the tick cycle therefore
    // survives for the following tick.
    // ------------------------------------------------------------------------
    always_comb begin
        held_plain_d = (held_plain_q | set_plain) & ~clr_plain;
        held_ext_d   = (held_ext_q   | set_ext)   & ~clr_ext;
        pend_d       = (tick ? 3'b000 : pend_q) | set_plain | set_ext;
    end

    // ------------------------------------------------------------------------
    // Pulse generation. The request is taken from register values in the
    // tick cycle, and the registered pulses appear in the following cycle.
    // Forward and backward cancel each other out when both are requested.
    // ------------------------------------------------------------------------
    assign eff = held_plain_q | held_ext_q | pend_q;

    always_comb begin
        forward_d  = 1'b0;
        backward_d = 1'b0;
        rotate_d   = 1'b0;
        if (tick) begin
            forward_d  = eff[BIT_FWD]  & ~eff[BIT_BACK];
            backward_d = eff[BIT_BACK] & ~eff[BIT_FWD];
            rotate_d   = eff[BIT_ROT];
        end
    end

    // ------------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            count_q      <= '0;
            held_plain_q <= 3'b000;
            held_ext_q   <= 3'b000;
            pend_q       <= 3'b000;
            forward_q    <= 1'b0;
            backward_q   <= 1'b0;
            rotate_q     <= 1'b0;
        end else begin
            count_q      <= count_d;
            held_plain_q <= held_plain_d;
            held_ext_q   <= held_ext_d;
            pend_q       <= pend_d;
            forward_q    <= forward_d;
            backward_q   <= backward_d;
            rotate_q     <= rotate_d;
        end
    end

    assign forward   = forward_q;
    assign backward  = backward_q;
    assign rotate    = rotate_q;
    assign keys_held = held_plain_q | held_ext_q;

endmodule

// File: tb/tb_ps2_movement_decoder.sv
// ============================================================================
// tb_ps2_movement_decoder
// ----------------------------------------------------------------------------
// Directed scoreboard bench for ps2_movement_decoder with TICK_DIV = 4.
// The stimulus process sends key bytes inside one tick period. It then pushes
// the hand-computed {rot, back, fwd} pulse pattern that the tick at the end
// of that period must produce. The monitor pops one entry in every post-tick
// cycle. In all other cycles it requires the pulses to be quiet, and it also
// checks the tick spacing and the reset state.
// ============================================================================
module tb_ps2_movement_decoder;

    localparam int TICK_DIV = 4;

    logic       clock;
    logic       reset;
    logic [7:0] scancode;
    logic       scancode_valid;
    logic       forward;
    logic       backward;
    logic       rotate;
    logic [2:0] keys_held;
    logic       tick;

    logic [2:0] exp_q[$];
    int         compared   = 0;
    int         mismatched = 0;

    ps2_movement_decoder #(
        .TICK_DIV (TICK_DIV),
        .KEY_FWD  (8'h1D),
        .KEY_BACK (8'h1B),
        .KEY_ROT  (8'h23)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .scancode       (scancode),
        .scancode_valid (scancode_valid),
        .forward        (forward),
        .backward       (backward),
        .rotate         (rotate),
        .keys_held      (keys_held),
        .tick           (tick)
    );

    // Free-running clock, 10 ns period.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Single comparison point: counts every check and reports failures.
    task automatic checkOutput(input string name, input logic [7:0] actual,
                               input logic [7:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    int cyc = 0;
    int last_tick_cyc = 0;
    bit have_tick = 1'b0;
    bit prev_tick = 1'b0;
    logic [2:0] exp_val;

    always @(negedge clock) begin
        cyc++;
        if (reset) begin
            prev_tick = 1'b0;
            have_tick = 1'b0;
            checkOutput("reset_state", {1'b0, tick, rotate, backward, forward, keys_held}, 8'h00);
        end else begin
            if (prev_tick) begin
                if (exp_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("[TB] FAIL pulse: got %b expected <no entry> at %0t",
                             {rotate, backward, forward}, $time);
                end else begin
                    exp_val = exp_q.pop_front();
                    checkOutput("pulse", {5'b0, rotate, backward, forward}, {5'b0, exp_val});
                end
            end else begin
                checkOutput("quiet", {5'b0, rotate, backward, forward}, 8'h00);
            end
            if (tick) begin
                if (have_tick) checkOutput("tick_period", 8'(cyc - last_tick_cyc), 8'(TICK_DIV));
                have_tick     = 1'b1;
                last_tick_cyc = cyc;
            end
            prev_tick = tick;
        end
    end

    // Move to just after the next falling edge. Inputs change here, so they
    // never race the monitor.
    task automatic step();
        @(negedge clock);
        #1;
    endtask

    // Return inside the tick cycle (falling edge + 1), with a bounded wait.
    task automatic waitTick();
        int guard;
        guard = 0;
        while (!tick && guard < 20) begin
            step();
            guard++;
        end
        if (!tick) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL tick_wait: got no tick expected tick within 20 cycles");
        end
    endtask

    // Push the expectation for the coming tick, wait for that tick, and land
    // in its post-tick cycle.
    task automatic syncTick(input logic [2:0] e);
        exp_q.push_back(e);
        waitTick();
        step();
    endtask

    // Send up to three bytes back to back in one tick period, starting in the
    // post-tick cycle. Record the pulse pattern that the next tick produces.
    task automatic applyStimulus(input logic [7:0] b0, input logic [7:0] b1,
                                 input logic [7:0] b2, input int n,
                                 input logic [2:0] e);
        logic [7:0] bytes [3];
        bytes[0] = b0;
        bytes[1] = b1;
        bytes[2] = b2;
        for (int i = 0; i < n; i++) begin
            scancode       = bytes[i];
            scancode_valid = 1'b1;
            step();
        end
        scancode_valid = 1'b0;
        syncTick(e);
    endtask

    // Push the expectation for the coming tick, then deliver one byte in the
    // tick cycle itself.
    task automatic applyLate(input logic [7:0] b, input logic [2:0] e);
        exp_q.push_back(e);
        waitTick();
        scancode       = b;
        scancode_valid = 1'b1;
        step();
        scancode_valid = 1'b0;
    endtask

    initial begin
        reset          = 1'b1;
        scancode       = 8'h00;
        scancode_valid = 1'b0;

        // 1: reset for three cycles, then idle for about 40 cycles.
        step(); step(); step();
        reset = 1'b0;
        syncTick(3'b000);
        for (int i = 0; i < 9; i++) applyStimulus(8'h00, 8'h00, 8'h00, 0, 3'b000);
        checkOutput("held_idle", {5'b0, keys_held}, 8'h00);

        // 2: hold W, then release it.
        applyStimulus(8'h1D, 8'h00, 8'h00, 1, 3'b001);
        applyStimulus(8'h00, 8'h00, 8'h00, 0, 3'b001);
        applyStimulus(8'h1D, 8'h00, 8'h00, 1, 3'b001);
        checkOutput("held_w", {5'b0, keys_held}, 8'h01);
        applyStimulus(8'hF0, 8'h1D, 8'h00, 2, 3'b000);
        checkOutput("held_w_rel", {5'b0, keys_held}, 8'h00);
        applyStimulus(8'h00, 8'h00, 8'h00, 0, 3'b000);

        // 3: extended Up, then Right, then release Up.
        applyStimulus(8'hE0, 8'h75, 8'h00, 2, 3'b001);
        applyStimulus(8'hE0, 8'h74, 8'h00, 2, 3'b101);
        applyStimulus(8'h00, 8'h00, 8'h00, 0, 3'b101);
        checkOutput("held_up_right", {5'b0, keys_held}, 8'h05);
        applyStimulus(8'hE0, 8'hF0, 8'h75, 3, 3'b100);
        applyStimulus(8'h00, 8'h00, 8'h00, 0, 3'b100);
        checkOutput("held_right", {5'b0, keys_held}, 8'h04);
        applyStimulus(8'hE0, 8'hF0, 8'h74, 3, 3'b000);
        checkOutput("held_ext_rel", {5'b0, keys_held}, 8'h00);

        // 3b: extended Down, press and release.
        applyStimulus(8'hE0, 8'h72, 8'h00, 2, 3'b010);
        applyStimulus(8'hE0, 8'hF0, 8'h72, 3, 3'b000);

        // 4: a tap inside one period still gives exactly one pulse.
        applyStimulus(8'h1D, 8'hF0, 8'h1D, 3, 3'b001);
        applyStimulus(8'h00, 8'h00, 8'h00, 0, 3'b000);
        checkOutput("held_tap", {5'b0, keys_held}, 8'h00);

        // 5: W and S together cancel, and forward resumes once S is released.
        applyStimulus(8'h1D, 8'h1B, 8'h00, 2, 3'b000);
        checkOutput("held_ws", {5'b0, keys_held}, 8'h03);
        applyStimulus(8'h00, 8'h00, 8'h00, 0, 3'b000);
        applyStimulus(8'hF0, 8'h1B, 8'h00, 2, 3'b001);
        applyStimulus(8'h00, 8'h00, 8'h00, 0, 3'b001);
        applyStimulus(8'hF0, 8'h1D, 8'h00, 2, 3'b000);

        // Unmapped bytes have no effect.
        applyStimulus(8'hAA, 8'hFA, 8'hE1, 3, 3'b000);
        checkOutput("held_unmapped", {5'b0, keys_held}, 8'h00);

        // A tap whose make lands in the tick cycle moves at the next tick.
        applyLate(8'h1D, 3'b000);
        applyStimulus(8'hF0, 8'h1D, 8'h00, 2, 3'b001);
        applyStimulus(8'h00, 8'h00, 8'h00, 0, 3'b000);

        // 6: reset after E0 discards the prefix.
        scancode       = 8'hE0;
        scancode_valid = 1'b1;
        step();
        scancode_valid = 1'b0;
        reset          = 1'b1;
        step(); step();
        reset = 1'b0;
        syncTick(3'b000);
        applyStimulus(8'h75, 8'h00, 8'h00, 1, 3'b000);
        checkOutput("held_after_reset", {5'b0, keys_held}, 8'h00);
        applyStimulus(8'h00, 8'h00, 8'h00, 0, 3'b000);

        step(); step();
        checkOutput("queue_empty", 8'(exp_q.size()), 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
